// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// Writeback selects, forwarding-select encodings and the sequencer state type.
package pipe_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_M   = 2'b01;
    localparam logic [1:0] FWD_W   = 2'b10;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // A later stage can supply rs only if it writes a non-x0 register with the same index.
    function automatic logic reg_hit(input logic wr_en, input logic [4:0] rd, input logic [4:0] rs);
        return wr_en && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational E-stage operand forwarding selects.
// The M stage holds the younger result, so it beats W when both match.
module hazard_fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs1_addrE,
    input  logic [4:0] rs2_addrE,
    input  logic [4:0] rd_addrM,
    input  logic       rd_wr_enM,
    input  logic [4:0] rd_addrW,
    input  logic       rd_wr_enW,
    output logic [1:0] fwd_aE,
    output logic [1:0] fwd_bE
);

    always_comb begin
        fwd_aE = FWD_REG;
        if (reg_hit(rd_wr_enM, rd_addrM, rs1_addrE)) begin
            fwd_aE = FWD_M;
        end else if (reg_hit(rd_wr_enW, rd_addrW, rs1_addrE)) begin
            fwd_aE = FWD_W;
        end
    end

    always_comb begin
        fwd_bE = FWD_REG;
        if (reg_hit(rd_wr_enM, rd_addrM, rs2_addrE)) begin
            fwd_bE = FWD_M;
        end else if (reg_hit(rd_wr_enW, rd_addrW, rs2_addrE)) begin
            fwd_bE = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage RV32I pipeline.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_addrD,
    input  logic [4:0]       rs2_addrD,
    input  logic [4:0]       rs1_addrE,
    input  logic [4:0]       rs2_addrE,
    input  logic [4:0]       rd_addrE,
    input  logic             rd_wr_enE,
    input  logic [1:0]       wb_selE,
    input  logic [4:0]       rd_addrM,
    input  logic             rd_wr_enM,
    input  logic [4:0]       rd_addrW,
    input  logic             rd_wr_enW,
    input  logic             br_takenE,
    input  logic             mem_reqM,
    input  logic             mem_ackM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       fwd_aE,
    output logic [1:0]       fwd_bE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

    hz_state_t  state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       mem_stall;
    logic       mem_timeout;
    logic       lu_cond;
    logic       lu_fire;
    logic       lu_done;

    hazard_fwd_unit u_fwd (
        .rs1_addrE (rs1_addrE),
        .rs2_addrE (rs2_addrE),
        .rd_addrM  (rd_addrM),
        .rd_wr_enM (rd_wr_enM),
        .rd_addrW  (rd_addrW),
        .rd_wr_enW (rd_wr_enW),
        .fwd_aE    (fwd_aE),
        .fwd_bE    (fwd_bE)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            wait_cnt <= 8'd0;
            lu_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            // Remember the load in E already got its bubble while it stays there.
            lu_done  <= lu_fire || (lu_cond && lu_done);
        end
    end

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        mem_stall   = 1'b0;
        mem_timeout = 1'b0;
        case (state)
            INIT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (mem_reqM && !mem_ackM) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = 8'd1;
                    mem_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                // An ack in the timeout cycle completes the access normally.
                mem_timeout = (wait_cnt == TIMEOUT_W) && !mem_ackM;
                if (mem_ackM || mem_timeout) begin
                    state_nxt = RUN;
                    wait_nxt  = 8'd0;
                end else begin
                    mem_stall = 1'b1;
                    wait_nxt  = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = INIT;
                wait_nxt  = 8'd0;
            end
        endcase
    end

    assign lu_cond = (wb_selE == WB_LOAD) && rd_wr_enE && (rd_addrE != 5'd0) &&
                     ((rd_addrE == rs1_addrD) || (rd_addrE == rs2_addrD));
    assign lu_fire = (state != INIT) && !mem_stall && !br_takenE && lu_cond && !lu_done;

    // Priority: post-reset flush, memory wait, redirect, load-use.
    always_comb begin
        stallF  = 1'b0;
        stallD  = 1'b0;
        stallE  = 1'b0;
        stallM  = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        flushW  = 1'b0;
        mem_err = 1'b0;
        if (rst_n) begin
            mem_err = mem_timeout;
            if (state == INIT) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (mem_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (br_takenE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (lu_fire) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, stallF};
            flush_q <= flush_q + {{(CNT_W-1){1'b0}}, flushE};
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
